// File: rtl/rp_8bit_io_timer.sv
// 8-bit timer/counter on the rp_8bit I/O bus: prescaler, TCNT, compare unit,
// overflow/compare flags with interrupt requests and a compare-toggle pin.
module rp_8bit_io_timer #(
  parameter logic [5:0]  BAS = 6'h30,
  parameter int unsigned PSW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic [1:0] irq_req,
  input  logic [1:0] irq_ack,
  output logic       tmr_oc
);

  localparam logic [5:0] OffTccr  = 6'd0;
  localparam logic [5:0] OffTcnt  = 6'd1;
  localparam logic [5:0] OffOcr   = 6'd2;
  localparam logic [5:0] OffTifr  = 6'd3;
  localparam logic [5:0] OffTimsk = 6'd4;

  logic [4:0]     tccr_q, tccr_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic [7:0]     ocr_q, ocr_d;
  logic [1:0]     tifr_q, tifr_d;
  logic [1:0]     timsk_q, timsk_d;
  logic [PSW-1:0] psc_q, psc_d;
  logic [7:0]     rdt_q, rdt_d;
  logic           oc_q, oc_d;

  logic [5:0]     off;
  logic           hit;
  logic           wr_tccr, wr_tcnt, wr_ocr, wr_tifr, wr_timsk;
  logic [2:0]     cs;
  logic           ctc, com;
  logic           run;
  logic [PSW-1:0] psc_mask;
  logic           tick;
  logic           tov_set, ocf_set;
  logic [1:0]     w1c;

  assign off      = io_adr - BAS;
  assign hit      = (io_adr >= BAS) && (off < 6'd5);
  assign wr_tccr  = io_wen && hit && (off == OffTccr);
  assign wr_tcnt  = io_wen && hit && (off == OffTcnt);
  assign wr_ocr   = io_wen && hit && (off == OffOcr);
  assign wr_tifr  = io_wen && hit && (off == OffTifr);
  assign wr_timsk = io_wen && hit && (off == OffTimsk);

  assign cs  = tccr_q[2:0];
  assign ctc = tccr_q[3];
  assign com = tccr_q[4];

  // Clock-select decode: mask is div-1, run is low for stop codes.
  always_comb begin
    run      = 1'b1;
    psc_mask = '0;
    case (cs)
      3'd1:    psc_mask = '0;
      3'd2:    psc_mask = PSW'(32'd7);
      3'd3:    psc_mask = PSW'(32'd63);
      3'd4:    psc_mask = PSW'(32'd255);
      3'd5:    psc_mask = PSW'(32'd1023);
      default: run      = 1'b0;
    endcase
  end

  assign tick  = run && ((psc_q & psc_mask) == psc_mask);
  assign psc_d = run ? psc_q + PSW'(1) : '0;

  // Counter next state; a CPU write to TCNT suppresses the tick entirely.
  always_comb begin
    tcnt_d  = tcnt_q;
    tov_set = 1'b0;
    ocf_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = (io_wdt & io_msk) | (tcnt_q & ~io_msk);
    end else if (tick) begin
      if (ctc && (tcnt_q == ocr_q)) begin
        tcnt_d  = 8'h00;
        ocf_set = 1'b1;
        tov_set = (ocr_q == 8'hFF);
      end else if (tcnt_q == 8'hFF) begin
        tcnt_d  = 8'h00;
        tov_set = 1'b1;
        ocf_set = (ocr_q == 8'hFF);
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
        ocf_set = (tcnt_q == ocr_q);
      end
    end
  end

  assign oc_d = oc_q ^ (ocf_set & com);

  // Hardware set dominates; ack and W1C both clear.
  assign w1c    = wr_tifr ? (io_wdt[1:0] & io_msk[1:0]) : 2'b00;
  assign tifr_d = {ocf_set, tov_set} | (tifr_q & ~irq_ack & ~w1c);

  assign tccr_d  = wr_tccr ? ((io_wdt[4:0] & io_msk[4:0]) | (tccr_q & ~io_msk[4:0])) : tccr_q;
  assign ocr_d   = wr_ocr ? ((io_wdt & io_msk) | (ocr_q & ~io_msk)) : ocr_q;
  assign timsk_d = wr_timsk ? ((io_wdt[1:0] & io_msk[1:0]) | (timsk_q & ~io_msk[1:0]))
                            : timsk_q;

  always_comb begin
    rdt_d = 8'h00;
    if (io_ren && hit) begin
      case (off)
        OffTccr:  rdt_d = {3'b000, tccr_q};
        OffTcnt:  rdt_d = tcnt_q;
        OffOcr:   rdt_d = ocr_q;
        OffTifr:  rdt_d = {6'b000000, tifr_q};
        OffTimsk: rdt_d = {6'b000000, timsk_q};
        default:  rdt_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tccr_q  <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tifr_q  <= '0;
      timsk_q <= '0;
      psc_q   <= '0;
      rdt_q   <= '0;
      oc_q    <= 1'b0;
    end else begin
      tccr_q  <= tccr_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      psc_q   <= psc_d;
      rdt_q   <= rdt_d;
      oc_q    <= oc_d;
    end
  end

  assign io_rdt  = rdt_q;
  assign irq_req = tifr_q & timsk_q;
  assign tmr_oc  = oc_q;

endmodule
